// File: rtl/ahbl_req_master.sv
// AHB-lite single-transfer master: one address-phase slot (A) and one data-phase
// slot (D), in-order one-cycle response pulses, two-cycle ERROR handling.
module ahbl_req_master #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [W_ADDR-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [W_DATA-1:0] req_wdata,

  output logic              rsp_valid,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic              ahblm_hwrite,
  output logic [1:0]        ahblm_htrans,
  output logic [2:0]        ahblm_hsize,
  output logic [2:0]        ahblm_hburst,
  output logic [3:0]        ahblm_hprot,
  output logic              ahblm_hmastlock,
  output logic [W_DATA-1:0] ahblm_hwdata,
  input  logic              ahblm_hready,
  input  logic              ahblm_hresp,
  input  logic [W_DATA-1:0] ahblm_hrdata
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  // A slot
  logic              a_valid_q, a_valid_d;
  logic              a_write_q, a_write_d;
  logic [W_ADDR-1:0] a_addr_q,  a_addr_d;
  logic [2:0]        a_size_q,  a_size_d;
  logic [W_DATA-1:0] a_wdata_q, a_wdata_d;

  // D slot
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [W_DATA-1:0] hwdata_q,  hwdata_d;

  logic              err_mask_q, err_mask_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [W_DATA-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  logic              accept;
  logic              advance;

  assign req_ready = !err_mask_q && (!a_valid_q || ahblm_hready);

  always_comb begin
    accept  = req_valid && req_ready;
    advance = a_valid_q && !err_mask_q && ahblm_hready;

    a_valid_d   = a_valid_q;
    a_write_d   = a_write_q;
    a_addr_d    = a_addr_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    // Mask only the first ERROR cycle, so the pending A transfer is cancelled once.
    err_mask_d = d_valid_q && ahblm_hresp && !ahblm_hready && !err_mask_q;

    if (ahblm_hready) begin
      if (d_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = d_write_q ? '0 : ahblm_hrdata;
        rsp_err_d   = ahblm_hresp;
      end
      d_valid_d = advance;
      if (advance) begin
        d_write_d = a_write_q;
        hwdata_d  = a_wdata_q;
      end
    end

    if (accept) begin
      a_valid_d = 1'b1;
      a_write_d = req_write;
      a_addr_d  = req_addr;
      a_size_d  = (req_size == 2'd3) ? 3'b010 : {1'b0, req_size};
      a_wdata_d = req_wdata;
    end else if (advance) begin
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_write_q   <= 1'b0;
      a_addr_q    <= '0;
      a_size_q    <= '0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      err_mask_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_write_q   <= a_write_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      err_mask_q  <= err_mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign ahblm_haddr     = a_addr_q;
  assign ahblm_hwrite    = a_write_q;
  assign ahblm_hsize     = a_size_q;
  assign ahblm_htrans    = (a_valid_q && !err_mask_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahblm_hburst    = 3'b000;
  assign ahblm_hprot     = 4'b0011;
  assign ahblm_hmastlock = 1'b0;
  assign ahblm_hwdata    = hwdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahbl_req_master.sv
// Bench for ahbl_req_master: directed bus scenarios with a response scoreboard.
module tb_ahbl_req_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ahblm_haddr;
  logic        ahblm_hwrite;
  logic [1:0]  ahblm_htrans;
  logic [2:0]  ahblm_hsize;
  logic [2:0]  ahblm_hburst;
  logic [3:0]  ahblm_hprot;
  logic        ahblm_hmastlock;
  logic [31:0] ahblm_hwdata;
  logic        ahblm_hready;
  logic        ahblm_hresp;
  logic [31:0] ahblm_hrdata;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  ahbl_req_master #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_size        (req_size),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .ahblm_haddr     (ahblm_haddr),
    .ahblm_hwrite    (ahblm_hwrite),
    .ahblm_htrans    (ahblm_htrans),
    .ahblm_hsize     (ahblm_hsize),
    .ahblm_hburst    (ahblm_hburst),
    .ahblm_hprot     (ahblm_hprot),
    .ahblm_hmastlock (ahblm_hmastlock),
    .ahblm_hwdata    (ahblm_hwdata),
    .ahblm_hready    (ahblm_hready),
    .ahblm_hresp     (ahblm_hresp),
    .ahblm_hrdata    (ahblm_hrdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_wdata = d;
  endtask

  // Pops one expected response per rsp_valid pulse; a pulse with nothing queued is an error.
  task automatic rsp_monitor();
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rsp: got rsp err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin
            n_err++;
            $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                     rsp_err, rsp_rdata, e.err, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize, ahblm_hwdata} !== 70'd0) begin
      n_err++;
      $display("FAIL reset_bus: got htrans=%b haddr=%h hwrite=%b hsize=%b hwdata=%h, required all 0",
               ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize, ahblm_hwdata);
    end
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_err, req_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_rsp: got rsp_valid=%b rdata=%h err=%b req_ready=%b, required 0/0/0/1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    n_cmp++;
    if ({ahblm_hburst, ahblm_hprot, ahblm_hmastlock} !== {3'b000, 4'b0011, 1'b0}) begin
      n_err++;
      $display("FAIL tie_offs: got hburst=%b hprot=%b hmastlock=%b, required 000/0011/0",
               ahblm_hburst, ahblm_hprot, ahblm_hmastlock);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_read();
    drive_req(1'b0, 32'h100, 2'd2, 32'h0);
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL rd_ready: got %b, required 1", req_ready);
    end
    cyc();
    req_valid = 1'b0;
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize} !== {2'b10, 32'h100, 1'b0, 3'b010}) begin
      n_err++;
      $display("FAIL rd_addr_phase: got htrans=%b haddr=%h hwrite=%b hsize=%b, required 10/00000100/0/010",
               ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize);
    end
    ahblm_hrdata = 32'hCAFEF00D;
    cyc();
    n_cmp++;
    if ({ahblm_htrans, rsp_valid} !== {2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL rd_data_phase: got htrans=%b rsp_valid=%b, required 00/0", ahblm_htrans, rsp_valid);
    end
    cyc();
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL rd_rsp_latency: got rsp_valid=%b at cycle 3, required 1", rsp_valid);
    end
    ahblm_hrdata = 32'h0;
    cyc();
  endtask

  task automatic test_back_to_back();
    drive_req(1'b1, 32'h0, 2'd2, 32'h11111111);
    exp_q.push_back({1'b0, 32'h0});
    cyc();
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize} !== {2'b10, 32'h0, 1'b1, 3'b010}) begin
      n_err++;
      $display("FAIL b2b_addr0: got htrans=%b haddr=%h hwrite=%b hsize=%b, required 10/00000000/1/010",
               ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize);
    end
    drive_req(1'b1, 32'h4, 2'd2, 32'h22222222);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready: got %b, required 1 with A full and hready=1", req_ready);
    end
    exp_q.push_back({1'b0, 32'h0});
    cyc();
    req_valid = 1'b0;
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr, ahblm_hwdata} !== {2'b10, 32'h4, 32'h11111111}) begin
      n_err++;
      $display("FAIL b2b_addr1: got htrans=%b haddr=%h hwdata=%h, required 10/00000004/11111111",
               ahblm_htrans, ahblm_haddr, ahblm_hwdata);
    end
    cyc();
    n_cmp++;
    if ({ahblm_htrans, ahblm_hwdata, rsp_valid} !== {2'b00, 32'h22222222, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_data1: got htrans=%b hwdata=%h rsp_valid=%b, required 00/22222222/1",
               ahblm_htrans, ahblm_hwdata, rsp_valid);
    end
    cyc();
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_rsp2: got rsp_valid=%b, required 1", rsp_valid);
    end
    cyc();
  endtask

  task automatic test_wait_states();
    drive_req(1'b1, 32'h20, 2'd2, 32'h33333333);
    exp_q.push_back({1'b0, 32'h0});
    cyc();
    drive_req(1'b1, 32'h24, 2'd2, 32'h44444444);
    exp_q.push_back({1'b0, 32'h0});
    cyc();
    req_valid    = 1'b0;
    ahblm_hready = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++; $display("FAIL ws_ready: got %b, required 0 with A full and hready=0", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if ({ahblm_htrans, ahblm_haddr, ahblm_hwdata, rsp_valid, req_ready} !==
          {2'b10, 32'h24, 32'h33333333, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL ws_hold%0d: got htrans=%b haddr=%h hwdata=%h rsp_valid=%b req_ready=%b, required 10/00000024/33333333/0/0",
                 i, ahblm_htrans, ahblm_haddr, ahblm_hwdata, rsp_valid, req_ready);
      end
    end
    ahblm_hready = 1'b1;
    cyc();
    n_cmp++;
    if ({rsp_valid, ahblm_hwdata, ahblm_htrans} !== {1'b1, 32'h44444444, 2'b00}) begin
      n_err++;
      $display("FAIL ws_release: got rsp_valid=%b hwdata=%h htrans=%b, required 1/44444444/00",
               rsp_valid, ahblm_hwdata, ahblm_htrans);
    end
    cyc();
    cyc();
  endtask

  task automatic test_error();
    drive_req(1'b0, 32'h40, 2'd2, 32'h0);
    exp_q.push_back({1'b1, 32'h0BAD0BAD});
    cyc();
    drive_req(1'b0, 32'h8, 2'd2, 32'h0);
    exp_q.push_back({1'b0, 32'h88888888});
    cyc();
    req_valid    = 1'b0;
    ahblm_hready = 1'b0;
    ahblm_hresp  = 1'b1;
    ahblm_hrdata = 32'h0BAD0BAD;
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr} !== {2'b10, 32'h8}) begin
      n_err++;
      $display("FAIL err_first: got htrans=%b haddr=%h, required 10/00000008", ahblm_htrans, ahblm_haddr);
    end
    cyc();
    ahblm_hready = 1'b1;
    #1;
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr, req_ready} !== {2'b00, 32'h8, 1'b0}) begin
      n_err++;
      $display("FAIL err_second: got htrans=%b haddr=%h req_ready=%b, required 00/00000008/0",
               ahblm_htrans, ahblm_haddr, req_ready);
    end
    cyc();
    ahblm_hresp  = 1'b0;
    ahblm_hrdata = 32'h88888888;
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr, rsp_valid, rsp_err} !== {2'b10, 32'h8, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL err_reissue: got htrans=%b haddr=%h rsp_valid=%b rsp_err=%b, required 10/00000008/1/1",
               ahblm_htrans, ahblm_haddr, rsp_valid, rsp_err);
    end
    cyc();
    n_cmp++;
    if ({ahblm_htrans, rsp_valid} !== {2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL err_retry_data: got htrans=%b rsp_valid=%b, required 00/0", ahblm_htrans, rsp_valid);
    end
    cyc();
    n_cmp++;
    if ({rsp_valid, rsp_err} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL err_retry_rsp: got rsp_valid=%b rsp_err=%b, required 1/0", rsp_valid, rsp_err);
    end
    ahblm_hrdata = 32'h0;
    cyc();
  endtask

  task automatic test_sizes();
    drive_req(1'b1, 32'h3, 2'd0, 32'hAB000000);
    exp_q.push_back({1'b0, 32'h0});
    cyc();
    drive_req(1'b0, 32'h10, 2'd3, 32'h0);
    exp_q.push_back({1'b0, 32'h12345678});
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize} !== {2'b10, 32'h3, 1'b1, 3'b000}) begin
      n_err++;
      $display("FAIL byte_addr: got htrans=%b haddr=%h hwrite=%b hsize=%b, required 10/00000003/1/000",
               ahblm_htrans, ahblm_haddr, ahblm_hwrite, ahblm_hsize);
    end
    cyc();
    req_valid    = 1'b0;
    ahblm_hrdata = 32'h12345678;
    n_cmp++;
    if ({ahblm_hwdata, ahblm_htrans, ahblm_hsize, ahblm_haddr} !== {32'hAB000000, 2'b10, 3'b010, 32'h10}) begin
      n_err++;
      $display("FAIL byte_data_size3: got hwdata=%h htrans=%b hsize=%b haddr=%h, required AB000000/10/010/00000010",
               ahblm_hwdata, ahblm_htrans, ahblm_hsize, ahblm_haddr);
    end
    cyc();
    cyc();
    ahblm_hrdata = 32'h0;
    cyc();
  endtask

  task automatic test_reset_mid();
    drive_req(1'b1, 32'h50, 2'd2, 32'h55555555);
    cyc();
    drive_req(1'b1, 32'h54, 2'd2, 32'h66666666);
    cyc();
    req_valid    = 1'b0;
    ahblm_hready = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr, ahblm_hwdata, rsp_valid, req_ready} !== {2'b00, 32'h0, 32'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid: got htrans=%b haddr=%h hwdata=%h rsp_valid=%b req_ready=%b, required 00/0/0/0/1",
               ahblm_htrans, ahblm_haddr, ahblm_hwdata, rsp_valid, req_ready);
    end
    ahblm_hready = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_release_ready: got %b, required 1", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++;
      if ({ahblm_htrans, rsp_valid} !== {2'b00, 1'b0}) begin
        n_err++;
        $display("FAIL rst_quiet%0d: got htrans=%b rsp_valid=%b, required 00/0", i, ahblm_htrans, rsp_valid);
      end
    end
    drive_req(1'b0, 32'h60, 2'd2, 32'h0);
    exp_q.push_back({1'b0, 32'h77777777});
    ahblm_hrdata = 32'h77777777;
    cyc();
    req_valid = 1'b0;
    n_cmp++;
    if ({ahblm_htrans, ahblm_haddr} !== {2'b10, 32'h60}) begin
      n_err++;
      $display("FAIL rst_resume: got htrans=%b haddr=%h, required 10/00000060", ahblm_htrans, ahblm_haddr);
    end
    cyc();
    cyc();
    ahblm_hrdata = 32'h0;
    cyc();
  endtask

  task automatic test_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 20) begin
      cyc();
      i++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d responses still outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_wdata    = '0;
    ahblm_hready = 1'b1;
    ahblm_hresp  = 1'b0;
    ahblm_hrdata = '0;
    fork
      rsp_monitor();
      begin
        #100000;
        $display("FAIL watchdog: got simulation still running at 100000, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_sizes();
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
